alu_issue_stage: RTL
====================

// Module: alu_issue_stage
// PURPOSE
//  Driving end of the ALU interface in the pipelined MIPS datapath. Decodes an ID-stage instruction
//  into the 4-bit ALU control code and selects/extends the ALU operands. Holds them in the ID/EX
//  register with stall/flush. Takes back the ALU zero flag in EX to resolve BEQ/BNE and redirect
//  fetch.
// PARAMETERS
//  CNT_W     32  width of the issued-instruction counter
// PORTS
//  clk            in   1   rising-edge clock
//  reset          in   1   synchronous, active-high reset
//  id_valid       in   1   ID holds a valid instruction
//  id_ready       out  1   = ~stall; ID instruction is consumed on id_valid & id_ready
//  id_instr       in   32  instruction word
//  id_pc4         in   32  PC+4 of that instruction
//  id_rs_val      in   32  register-file value of rs
//  id_rt_val      in   32  register-file value of rt
//  stall          in   1   hazard unit: hold ID/EX, suppress branch resolution
//  alu_entr1      out  32  registered operand 1 to ALU
//  alu_entr2      out  32  registered operand 2 to ALU
//  alu_ctrl       out  4   registered ALU control code
//  alu_zero       in   1   ALU zero flag (combinational in EX)
//  ex_valid       out  1   ID/EX holds a real instruction (0 = bubble)
//  ex_rd          out  5   destination register
//  ex_reg_write   out  1   write-back enable (0 when bubble)
//  ex_mem_read    out  1   lw
//  ex_mem_write   out  1   sw
//  ex_store_data  out  32  rt value for sw
//  ex_illegal     out  1   unsupported opcode/funct was issued as bubble
//  branch_taken   out  1   combinational redirect request
//  branch_target  out  32  id_pc4 of branch + (sign_ext(imm)<<2), registered
//  issue_count    out  CNT_W  count of valid (non-bubble) instructions loaded into ID/EX
// BEHAVIOUR
//  ALU codes: ADD 0000, SUB 0001, AND 0010, NOR 0011, OR 0100, SLT 0101, BEQ 0110, BNE 0111.
//  Decode (op/funct):
//   - R-type: add 100000, sub 100010, and 100100, or 100101, nor 100111, slt 101010; rd = instr[15:11].
//   - addi 001000 ADD; slti 001010 SLT; andi 001100 AND; ori 001101 OR.
//   - lw 100011 ADD; sw 101011 ADD.
//   - beq 000100 BEQ; bne 000101 BNE.
//   - I-type rd = instr[20:16].
//  Immediates: andi/ori zero-extend; addi/slti/lw/sw/beq/bne sign-extend.
//  Operands:
//   - Default entr1 = rs, entr2 = rt or imm.
//   - SLT/SLTI swap the operands: entr1 = rt/imm, entr2 = rs. The ALU computes entr1>entr2, so this
//     yields rs<rt.
//  reg_write = 1 for R-type, addi, slti, andi, ori, lw. It is 0 for sw, beq, bne, illegal, and bubbles.
//  Illegal op/funct: loads a bubble with ex_illegal = 1 for one EX cycle. It is not counted.
//  ID/EX update priority each cycle: reset > flush (branch_taken) > stall > load.
//   - reset: all ID/EX outputs 0, alu_ctrl = 4'b0000, branch_target = 0, issue_count = 0.
//   - flush: load bubble. The concurrent ID instruction is consumed and dropped.
//   - stall: hold every ID/EX field. id_ready = 0. branch_taken is forced to 0.
//   - load: if id_valid, register the decode. Otherwise load a bubble.
//  Bubble: ex_valid = 0, ctrl signals 0, alu_ctrl = 0000, operands 0.
//  Latency: one cycle from ID acceptance to ALU inputs.
//  branch_taken = ex_valid & ~stall & ((alu_ctrl==BEQ & alu_zero) | (alu_ctrl==BNE & alu_zero)).
//   - The ALU zero flag is 1 on BNE when the operands differ.
//   - Asserted for exactly one cycle per taken branch.
//  Back-to-back branches: a branch following a taken branch is flushed and never resolves.
//  issue_count wraps modulo 2^CNT_W. It increments only on a load with a legal instruction.
//  Reset mid-stall or mid-branch: reset wins. branch_taken = 0 in the reset cycle and the next.
// TESTING
//  1. Reset: assert reset 2 cycles. Check ex_valid = 0, alu_ctrl = 0, branch_taken = 0, issue_count = 0.
//  2. addi $t0,$s0,-1 (rs=5) -> next cycle alu_ctrl=0000, entr1=5, entr2=32'hFFFFFFFF, ex_rd=8,
//     reg_write=1. ori imm 0x8000 -> entr2=32'h00008000.
//  3. slt rs=3, rt=7 -> alu_ctrl=0101, entr1=7, entr2=3 (ALU result 1). Same for slti imm=7.
//  4. beq rs=rt=9, pc4=0x100, imm=4 -> branch_taken=1 in EX, target=0x110.
//     The ID instruction in that cycle is dropped: next ex_valid=0, issue_count unchanged.
//     bne with equal operands -> no branch.
//  5. Assert stall 3 cycles over a loaded add -> ID/EX held, id_ready=0. A held beq does not
//     assert branch_taken until stall deasserts, then exactly 1 cycle.
//  6. Illegal funct 000000 with op 0 -> bubble, ex_illegal=1 for 1 cycle, reg_write=0.
//     With CNT_W=4, issuing 17 legal instructions wraps issue_count to 1.

Source files
------------

// File: rtl/alu_issue_stage.sv
// Purpose : ID-stage decode for the MIPS ALU, the ID/EX pipeline register, and BEQ/BNE resolution from the ALU zero flag.
// Latency : 1 cycle from ID acceptance to ALU operands; branch_taken is combinational in EX.
// Backpr. : stall holds ID/EX and drops id_ready; a taken branch flushes ID/EX and drops the concurrent ID instruction.
//
// Ports:
//   clk, reset                 rising-edge clock, synchronous active-high reset
//   id_valid/id_ready          ID handshake; id_ready = ~stall
//   id_instr, id_pc4           instruction word and its PC+4
//   id_rs_val, id_rt_val       register-file operands
//   stall                      hazard-unit hold request
//   alu_entr1/2, alu_ctrl      registered ALU operands and 4-bit control code
//   alu_zero                   ALU zero flag from EX
//   ex_*                       registered EX-stage control and data
//   branch_taken/target        fetch redirect request and registered target
//   issue_count                number of legal instructions loaded into ID/EX (wraps)
module alu_issue_stage #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    output logic             id_ready,
    input  logic [31:0]      id_instr,
    input  logic [31:0]      id_pc4,
    input  logic [31:0]      id_rs_val,
    input  logic [31:0]      id_rt_val,
    input  logic             stall,
    output logic [31:0]      alu_entr1,
    output logic [31:0]      alu_entr2,
    output logic [3:0]       alu_ctrl,
    input  logic             alu_zero,
    output logic             ex_valid,
    output logic [4:0]       ex_rd,
    output logic             ex_reg_write,
    output logic             ex_mem_read,
    output logic             ex_mem_write,
    output logic [31:0]      ex_store_data,
    output logic             ex_illegal,
    output logic             branch_taken,
    output logic [31:0]      branch_target,
    output logic [CNT_W-1:0] issue_count
);

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_NOR = 4'b0011;
    localparam logic [3:0] ALU_OR  = 4'b0100;
    localparam logic [3:0] ALU_SLT = 4'b0101;
    localparam logic [3:0] ALU_BEQ = 4'b0110;
    localparam logic [3:0] ALU_BNE = 4'b0111;

    // All ID/EX state in one record so a bubble is simply '0.
    typedef struct packed {
        logic        valid;
        logic        illegal;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic [3:0]  ctrl;
        logic [4:0]  rd;
        logic [31:0] entr1;
        logic [31:0] entr2;
        logic [31:0] store_data;
        logic [31:0] target;
    } idex_t;

    idex_t            ex_q;
    idex_t            dec;
    logic             dec_legal;
    logic             use_imm;
    logic             swap_ops;
    logic [31:0]      imm_val;
    logic [CNT_W-1:0] cnt_q;

    logic [5:0]  op;
    logic [5:0]  funct;
    logic [31:0] imm_sext;
    logic [31:0] imm_zext;

    // shamt is never consulted by the supported instruction set.
    logic unused_shamt;
    assign unused_shamt = ^id_instr[10:6];

    assign op       = id_instr[31:26];
    assign funct    = id_instr[5:0];
    assign imm_sext = {{16{id_instr[15]}}, id_instr[15:0]};
    assign imm_zext = {16'h0000, id_instr[15:0]};

    always_comb begin
        dec       = '0;
        dec_legal = 1'b1;
        use_imm   = 1'b1;
        swap_ops  = 1'b0;
        imm_val   = imm_sext;
        dec.rd    = id_instr[20:16];
        case (op)
            6'b000000: begin
                use_imm       = 1'b0;
                dec.rd        = id_instr[15:11];
                dec.reg_write = 1'b1;
                case (funct)
                    6'b100000: dec.ctrl = ALU_ADD;
                    6'b100010: dec.ctrl = ALU_SUB;
                    6'b100100: dec.ctrl = ALU_AND;
                    6'b100101: dec.ctrl = ALU_OR;
                    6'b100111: dec.ctrl = ALU_NOR;
                    6'b101010: begin
                        dec.ctrl = ALU_SLT;
                        swap_ops = 1'b1;
                    end
                    default:   dec_legal = 1'b0;
                endcase
            end
            6'b001000: begin dec.ctrl = ALU_ADD; dec.reg_write = 1'b1; end
            6'b001010: begin dec.ctrl = ALU_SLT; dec.reg_write = 1'b1; swap_ops = 1'b1; end
            6'b001100: begin dec.ctrl = ALU_AND; dec.reg_write = 1'b1; imm_val = imm_zext; end
            6'b001101: begin dec.ctrl = ALU_OR;  dec.reg_write = 1'b1; imm_val = imm_zext; end
            6'b100011: begin dec.ctrl = ALU_ADD; dec.reg_write = 1'b1; dec.mem_read = 1'b1; end
            6'b101011: begin
                dec.ctrl       = ALU_ADD;
                dec.mem_write  = 1'b1;
                dec.store_data = id_rt_val;
            end
            6'b000100: begin dec.ctrl = ALU_BEQ; use_imm = 1'b0; end
            6'b000101: begin dec.ctrl = ALU_BNE; use_imm = 1'b0; end
            default:   dec_legal = 1'b0;
        endcase

        // The ALU evaluates entr1 > entr2, so set-less-than feeds rs on the right.
        if (swap_ops) begin
            dec.entr1 = use_imm ? imm_val : id_rt_val;
            dec.entr2 = id_rs_val;
        end else begin
            dec.entr1 = id_rs_val;
            dec.entr2 = use_imm ? imm_val : id_rt_val;
        end

        if (dec.ctrl == ALU_BEQ || dec.ctrl == ALU_BNE) begin
            dec.target = id_pc4 + {imm_sext[29:0], 2'b00};
        end
        dec.valid = dec_legal;
    end

    // The ALU reports zero=1 for BNE when operands differ, so both branches
    // resolve on the same flag. reset is included so a branch sitting in EX
    // cannot redirect fetch in the reset cycle itself.
    assign branch_taken = ex_q.valid & ~stall & ~reset & alu_zero &
                          ((ex_q.ctrl == ALU_BEQ) | (ex_q.ctrl == ALU_BNE));

    assign id_ready = ~stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q  <= '0;
            cnt_q <= '0;
        end else if (branch_taken) begin
            ex_q <= '0;
        end else if (stall) begin
            ex_q <= ex_q;
        end else if (id_valid && dec_legal) begin
            ex_q  <= dec;
            cnt_q <= cnt_q + CNT_W'(1);
        end else if (id_valid) begin
            ex_q         <= '0;
            ex_q.illegal <= 1'b1;
        end else begin
            ex_q <= '0;
        end
    end

    assign alu_entr1     = ex_q.entr1;
    assign alu_entr2     = ex_q.entr2;
    assign alu_ctrl      = ex_q.ctrl;
    assign ex_valid      = ex_q.valid;
    assign ex_rd         = ex_q.rd;
    assign ex_reg_write  = ex_q.reg_write;
    assign ex_mem_read   = ex_q.mem_read;
    assign ex_mem_write  = ex_q.mem_write;
    assign ex_store_data = ex_q.store_data;
    assign ex_illegal    = ex_q.illegal;
    assign branch_target = ex_q.target;
    assign issue_count   = cnt_q;

endmodule
